// File: rtl/zero_mult_result_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : zero_mult_result_unit_pkg
// Description : Shared constants for the multiplier zero-operand result unit:
//               FSM state encoding, precision widths and the product-sign
//               helper.
// Revision    : 1.0 - initial release
// ============================================================================
package zero_mult_result_unit_pkg;

    // Operand widths for the two supported precisions
    localparam int c_w_single = 32;
    localparam int c_w_double = 64;

    // Sequencer state encoding
    localparam logic [2:0] c_st_idle  = 3'd0;
    localparam logic [2:0] c_st_load  = 3'd1;
    localparam logic [2:0] c_st_check = 3'd2;
    localparam logic [2:0] c_st_run   = 3'd3;
    localparam logic [2:0] c_st_done  = 3'd4;

    // Sign of any product, including a zero product
    function automatic logic product_sign(input logic a, input logic b);
        return a ^ b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/zero_mult_result_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : zero_mult_result_unit_if
// Description : Signal bundle between the zero-result sequencer and its
//               operand registers, zero-detect flag, multiplier core and the
//               downstream consumer. master = sequencer side.
// Revision    : 1.0 - initial release
// ============================================================================
interface zero_mult_result_unit_if #(
    parameter int W = 32
);
    logic         beg_op;
    logic         sign_a;
    logic         sign_b;
    logic         zero_load;
    logic         zero_m_flag;
    logic         core_start;
    logic         core_done;
    logic [W-1:0] core_result;
    logic         core_abort;
    logic [W-1:0] result;
    logic         ready;
    logic         zero_bypass;
    logic         timeout_err;
    logic         ack;

    modport master (
        input  beg_op, sign_a, sign_b, zero_m_flag, core_done, core_result, ack,
        output zero_load, core_start, core_abort, result, ready, zero_bypass,
               timeout_err
    );

    modport slave (
        output beg_op, sign_a, sign_b, zero_m_flag, core_done, core_result, ack,
        input  zero_load, core_start, core_abort, result, ready, zero_bypass,
               timeout_err
    );
endinterface
`default_nettype wire

// File: rtl/zero_mult_result_unit_timeout_counter.sv
`default_nettype none
// ============================================================================
// Module      : zero_mult_result_unit_timeout_counter
// Description : CW-bit cycle counter with synchronous clear and enable;
//               o_tc flags the last permitted cycle (count == TMO-1).
// Revision    : 1.0 - initial release
// ============================================================================
module zero_mult_result_unit_timeout_counter #(
    parameter int TMO = 64,
    parameter int CW  = 7
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic i_clr,
    input  wire logic i_en,
    output logic      o_tc
);
    localparam logic [CW-1:0] c_tc = CW'(TMO - 1);

    logic [CW-1:0] r_count;

    // Clear has priority so a fresh RUN always starts from zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_tc = (r_count == c_tc);

endmodule
`default_nettype wire

// File: rtl/zero_mult_result_unit.sv
`default_nettype none
// ============================================================================
// Module      : zero_mult_result_unit
// Description : Sequences one FP multiply: strobes the zero-detect flag load,
//               short-circuits zero operands to a signed zero, otherwise runs
//               the core with a timeout and holds the result until ack.
// Revision    : 1.0 - initial release
// ============================================================================
module zero_mult_result_unit
    import zero_mult_result_unit_pkg::*;
#(
    parameter int W   = c_w_single,
    parameter int TMO = 64,
    parameter int CW  = 7
) (
    input wire logic              clk,
    input wire logic              rst,
    zero_mult_result_unit_if.master bus
);
    logic [2:0]   r_state,        w_state_nxt;
    logic         r_sgn,          w_sgn_nxt;
    logic         r_zero_load,    w_zero_load_nxt;
    logic         r_core_start,   w_core_start_nxt;
    logic         r_core_abort,   w_core_abort_nxt;
    logic [W-1:0] r_result,       w_result_nxt;
    logic         r_ready,        w_ready_nxt;
    logic         r_zero_bypass,  w_zero_bypass_nxt;
    logic         r_timeout_err,  w_timeout_err_nxt;
    logic         w_cnt_clr;
    logic         w_cnt_en;
    logic         w_cnt_tc;

    zero_mult_result_unit_timeout_counter #(
        .TMO (TMO),
        .CW  (CW)
    ) u_timeout_counter (
        .clk   (clk),
        .rst   (rst),
        .i_clr (w_cnt_clr),
        .i_en  (w_cnt_en),
        .o_tc  (w_cnt_tc)
    );

    // Next-state and next-output decode; pulses default low, held values keep
    always_comb begin
        w_state_nxt       = r_state;
        w_sgn_nxt         = r_sgn;
        w_zero_load_nxt   = 1'b0;
        w_core_start_nxt  = 1'b0;
        w_core_abort_nxt  = 1'b0;
        w_result_nxt      = r_result;
        w_ready_nxt       = r_ready;
        w_zero_bypass_nxt = r_zero_bypass;
        w_timeout_err_nxt = r_timeout_err;
        w_cnt_clr         = 1'b0;
        w_cnt_en          = 1'b0;
        case (r_state)
            c_st_idle: begin
                if (bus.beg_op) begin
                    w_sgn_nxt       = product_sign(bus.sign_a, bus.sign_b);
                    w_zero_load_nxt = 1'b1;
                    w_state_nxt     = c_st_load;
                end
            end
            c_st_load: begin
                w_state_nxt = c_st_check;
            end
            c_st_check: begin
                if (bus.zero_m_flag) begin
                    w_result_nxt      = {r_sgn, {(W-1){1'b0}}};
                    w_zero_bypass_nxt = 1'b1;
                    w_ready_nxt       = 1'b1;
                    w_state_nxt       = c_st_done;
                end else begin
                    w_core_start_nxt = 1'b1;
                    w_cnt_clr        = 1'b1;
                    w_state_nxt      = c_st_run;
                end
            end
            c_st_run: begin
                w_cnt_en = 1'b1;
                // A result arriving on the expiry cycle still counts as success
                if (bus.core_done) begin
                    w_result_nxt = bus.core_result;
                    w_ready_nxt  = 1'b1;
                    w_state_nxt  = c_st_done;
                end else if (w_cnt_tc) begin
                    w_core_abort_nxt  = 1'b1;
                    w_timeout_err_nxt = 1'b1;
                    w_result_nxt      = '0;
                    w_ready_nxt       = 1'b1;
                    w_state_nxt       = c_st_done;
                end
            end
            c_st_done: begin
                // Result value is deliberately left in place after ack
                if (bus.ack) begin
                    w_ready_nxt       = 1'b0;
                    w_zero_bypass_nxt = 1'b0;
                    w_timeout_err_nxt = 1'b0;
                    w_state_nxt       = c_st_idle;
                end
            end
            default: begin
                w_state_nxt = c_st_idle;
            end
        endcase
    end

    // State and registered outputs; reset abandons any operation silently
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= c_st_idle;
            r_sgn         <= 1'b0;
            r_zero_load   <= 1'b0;
            r_core_start  <= 1'b0;
            r_core_abort  <= 1'b0;
            r_result      <= '0;
            r_ready       <= 1'b0;
            r_zero_bypass <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_sgn         <= w_sgn_nxt;
            r_zero_load   <= w_zero_load_nxt;
            r_core_start  <= w_core_start_nxt;
            r_core_abort  <= w_core_abort_nxt;
            r_result      <= w_result_nxt;
            r_ready       <= w_ready_nxt;
            r_zero_bypass <= w_zero_bypass_nxt;
            r_timeout_err <= w_timeout_err_nxt;
        end
    end

    assign bus.zero_load   = r_zero_load;
    assign bus.core_start  = r_core_start;
    assign bus.core_abort  = r_core_abort;
    assign bus.result      = r_result;
    assign bus.ready       = r_ready;
    assign bus.zero_bypass = r_zero_bypass;
    assign bus.timeout_err = r_timeout_err;

endmodule
`default_nettype wire

// File: tb/tb_zero_mult_result_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_zero_mult_result_unit
// Description : Directed bench for zero_mult_result_unit, single precision
//               instance plus a double precision instance for reset-in-RUN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_zero_mult_result_unit;

    logic clk = 1'b0;
    logic rst;
    logic rst_d;
    int   errors = 0;
    int   checks = 0;
    int   n_start32 = 0;
    int   n_abort32 = 0;
    int   n_abort64 = 0;

    always #5 clk = ~clk;

    zero_mult_result_unit_if #(.W(32)) bus32 ();
    zero_mult_result_unit_if #(.W(64)) bus64 ();

    zero_mult_result_unit #(.W(32), .TMO(64), .CW(7)) u_dut32 (
        .clk (clk),
        .rst (rst),
        .bus (bus32)
    );

    zero_mult_result_unit #(.W(64), .TMO(64), .CW(7)) u_dut64 (
        .clk (clk),
        .rst (rst_d),
        .bus (bus64)
    );

    // Pulse counters
    always @(negedge clk) begin
        if (bus32.core_start === 1'b1) n_start32++;
        if (bus32.core_abort === 1'b1) n_abort32++;
        if (bus64.core_abort === 1'b1) n_abort64++;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        rst_d = 1'b1;
        bus32.beg_op = 0; bus32.sign_a = 0; bus32.sign_b = 0; bus32.zero_m_flag = 0;
        bus32.core_done = 0; bus32.core_result = '0; bus32.ack = 0;
        bus64.beg_op = 0; bus64.sign_a = 0; bus64.sign_b = 0; bus64.zero_m_flag = 0;
        bus64.core_done = 0; bus64.core_result = '0; bus64.ack = 0;
        tick(1);
        chk("rst_ready",     bus32.ready, 0);
        chk("rst_result",    bus32.result, 0);
        chk("rst_zload",     bus32.zero_load, 0);
        chk("rst_start",     bus32.core_start, 0);
        chk("rst_abort",     bus32.core_abort, 0);
        chk("rst_bypass",    bus32.zero_bypass, 0);
        chk("rst_tmo",       bus32.timeout_err, 0);
        chk("rst_ready64",   bus64.ready, 0);
        rst = 1'b0;
        rst_d = 1'b0;
        tick(1);

        // Zero bypass, (-)x(+) -> -0
        bus32.sign_a = 1; bus32.sign_b = 0; bus32.zero_m_flag = 1; bus32.beg_op = 1;
        tick(1);
        bus32.beg_op = 0;
        chk("byp_zload_hi",  bus32.zero_load, 1);
        chk("byp_ready_lo1", bus32.ready, 0);
        tick(1);
        chk("byp_zload_lo",  bus32.zero_load, 0);
        chk("byp_ready_lo2", bus32.ready, 0);
        tick(1);
        chk("byp_ready",     bus32.ready, 1);
        chk("byp_result",    bus32.result, 64'h8000_0000);
        chk("byp_flag",      bus32.zero_bypass, 1);
        chk("byp_tmo",       bus32.timeout_err, 0);
        chk("byp_nostart",   n_start32, 0);
        bus32.ack = 1;
        tick(1);
        bus32.ack = 0;
        chk("byp_ack_ready", bus32.ready, 0);
        chk("byp_ack_flag",  bus32.zero_bypass, 0);
        chk("byp_ack_keep",  bus32.result, 64'h8000_0000);

        // Normal path, core_done 5 cycles after core_start
        bus32.sign_a = 0; bus32.sign_b = 0; bus32.zero_m_flag = 0; bus32.beg_op = 1;
        tick(1);
        bus32.beg_op = 0;
        tick(2);
        chk("nrm_start_hi",  bus32.core_start, 1);
        tick(1);
        chk("nrm_start_lo",  bus32.core_start, 0);
        bus32.beg_op = 1;
        tick(1);
        bus32.beg_op = 0;
        tick(3);
        bus32.core_done = 1; bus32.core_result = 32'h4040_0000;
        tick(1);
        bus32.core_done = 0;
        chk("nrm_ready",     bus32.ready, 1);
        chk("nrm_result",    bus32.result, 64'h4040_0000);
        chk("nrm_bypass",    bus32.zero_bypass, 0);
        chk("nrm_tmo",       bus32.timeout_err, 0);
        chk("nrm_one_start", n_start32, 1);

        // Hold in DONE for 10 cycles with a stray beg_op
        for (int i = 0; i < 10; i++) begin
            bus32.beg_op = (i == 3);
            tick(1);
            chk("hold_ready",  bus32.ready, 1);
            chk("hold_result", bus32.result, 64'h4040_0000);
        end
        bus32.ack = 1; bus32.beg_op = 1;
        tick(1);
        bus32.ack = 0; bus32.beg_op = 0;
        chk("ack_ready_lo",  bus32.ready, 0);
        tick(1);
        chk("ack_beg_ign",   bus32.zero_load, 0);
        chk("ack_idle_rdy",  bus32.ready, 0);

        // New request accepted after ack, (+)x(-) -> -0
        bus32.sign_a = 0; bus32.sign_b = 1; bus32.zero_m_flag = 1; bus32.beg_op = 1;
        tick(1);
        bus32.beg_op = 0;
        chk("new_zload",     bus32.zero_load, 1);
        tick(2);
        chk("new_ready",     bus32.ready, 1);
        chk("new_result",    bus32.result, 64'h8000_0000);
        chk("new_bypass",    bus32.zero_bypass, 1);
        bus32.ack = 1;
        tick(1);
        bus32.ack = 0;
        chk("new_ack",       bus32.ready, 0);

        // Timeout, core never answers
        bus32.sign_a = 0; bus32.sign_b = 0; bus32.zero_m_flag = 0; bus32.beg_op = 1;
        tick(1);
        bus32.beg_op = 0;
        tick(2);
        chk("tmo_start",     bus32.core_start, 1);
        tick(63);
        chk("tmo_abort_pre", bus32.core_abort, 0);
        chk("tmo_ready_pre", bus32.ready, 0);
        tick(1);
        chk("tmo_abort",     bus32.core_abort, 1);
        chk("tmo_err",       bus32.timeout_err, 1);
        chk("tmo_ready",     bus32.ready, 1);
        chk("tmo_result",    bus32.result, 0);
        chk("tmo_bypass",    bus32.zero_bypass, 0);
        tick(1);
        chk("tmo_abort_lo",  bus32.core_abort, 0);
        chk("tmo_ready_hld", bus32.ready, 1);
        chk("tmo_one_abort", n_abort32, 1);
        bus32.ack = 1;
        tick(1);
        bus32.ack = 0;
        chk("tmo_ack_rdy",   bus32.ready, 0);
        chk("tmo_ack_err",   bus32.timeout_err, 0);

        // core_done on the expiry cycle wins
        bus32.beg_op = 1;
        tick(1);
        bus32.beg_op = 0;
        tick(65);
        bus32.core_done = 1; bus32.core_result = 32'h3F80_0000;
        tick(1);
        bus32.core_done = 0;
        chk("race_abort",    bus32.core_abort, 0);
        chk("race_ready",    bus32.ready, 1);
        chk("race_result",   bus32.result, 64'h3F80_0000);
        chk("race_tmo",      bus32.timeout_err, 0);
        tick(1);
        chk("race_no_abort", n_abort32, 1);
        bus32.ack = 1;
        tick(1);
        bus32.ack = 0;

        // Double precision: async reset while in RUN
        bus64.sign_a = 0; bus64.sign_b = 0; bus64.zero_m_flag = 0; bus64.beg_op = 1;
        tick(1);
        bus64.beg_op = 0;
        tick(2);
        chk("d_start",       bus64.core_start, 1);
        #2 rst_d = 1'b1;
        #1;
        chk("d_rst_start",   bus64.core_start, 0);
        chk("d_rst_ready",   bus64.ready, 0);
        chk("d_rst_result",  bus64.result, 0);
        chk("d_rst_abort",   bus64.core_abort, 0);
        @(negedge clk);
        rst_d = 1'b0;
        tick(70);
        chk("d_no_abort",    n_abort64, 0);
        chk("d_idle_ready",  bus64.ready, 0);

        bus64.sign_a = 1; bus64.sign_b = 0; bus64.zero_m_flag = 1; bus64.beg_op = 1;
        tick(1);
        bus64.beg_op = 0;
        tick(2);
        chk("d_neg_ready",   bus64.ready, 1);
        chk("d_neg_result",  bus64.result, 64'h8000_0000_0000_0000);
        bus64.ack = 1;
        tick(1);
        bus64.ack = 0;

        bus64.sign_a = 1; bus64.sign_b = 1; bus64.beg_op = 1;
        tick(1);
        bus64.beg_op = 0;
        tick(2);
        chk("d_pos_ready",   bus64.ready, 1);
        chk("d_pos_result",  bus64.result, 64'h0);
        chk("d_pos_bypass",  bus64.zero_bypass, 1);
        bus64.ack = 1;
        tick(1);
        bus64.ack = 0;
        chk("d_pos_ack",     bus64.ready, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/zero_mult_result_unit.md
Name: zero_mult_result_unit

Overview:
- Consumer end of the multiplier zero-operand detection path.
- Sequences one FP multiply operation:
  - pulses the load of the zero-detect flag register;
  - samples the registered zero flag;
  - when an operand is zero, short-circuits the multiplier core and emits a correctly signed zero;
  - otherwise starts the core, waits for its result with a timeout, and holds the result for a downstream ready/ack handshake.
- Sits between the operand registers, the zero-detect unit and the multiplier datapath, in single or double precision.

Parameters:
- W, 32, operand/result width (32 single, 64 double).
- TMO, 64, max cycles in RUN before abort (must be ≥ 2).
- CW, 7, timeout counter width; must satisfy 2^CW > TMO.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- beg_op  in  1  start request; honoured only in IDLE.
- sign_a  in  1  sign bit of operand A (Data_A[W-1]), stable from beg_op until ready.
- sign_b  in  1  sign bit of operand B (Data_B[W-1]), same stability rule.
- zero_load  out  1  one-cycle load strobe to the zero-detect flag register.
- zero_m_flag  in  1  registered zero flag; valid the cycle after zero_load.
- core_start  out  1  one-cycle start pulse to the multiplier core.
- core_done  in  1  core result valid (single-cycle pulse).
- core_result  in  W  core product, valid with core_done.
- core_abort  out  1  one-cycle abort pulse to the core on timeout.
- result  out  W  final product, held while ready=1.
- ready  out  1  result valid; held until ack.
- zero_bypass  out  1  the result came from the zero short-circuit; valid with ready.
- timeout_err  out  1  the result is invalid because of a core timeout; valid with ready.
- ack  in  1  downstream consumed the result; honoured only in DONE.

Behaviour:
- Reset (async, active-high):
  - state=IDLE;
  - all outputs 0 (result=0, ready=0, pulses 0, flags 0);
  - counter=0, latched sign=0.
  - Reset mid-operation abandons the operation silently; core_abort is not pulsed.
- All outputs are registered; pulses last exactly one cycle.
- IDLE:
  - On beg_op=1: latch sgn=sign_a^sign_b, assert zero_load next cycle, go to LOAD.
  - Otherwise stay in IDLE.
- LOAD: zero_load=1 for this cycle only; go to CHECK.
- CHECK: sample zero_m_flag.
  - If 1: result={sgn,{W-1{1'b0}}}, zero_bypass=1, go to DONE. Total latency beg_op→ready is 3 cycles.
  - If 0: core_start=1 on the next cycle, counter=0, go to RUN.
- RUN:
  - Counter increments each cycle.
  - core_done=1: result=core_result, go to DONE.
  - Else if counter==TMO-1: core_abort=1, timeout_err=1, result=0, go to DONE.
  - core_done in the same cycle as counter expiry: core_done wins; no abort is issued.
- DONE: ready=1.
  - On ack=1: clear ready, zero_bypass, timeout_err (result is kept), go to IDLE.
  - ready drops the cycle after ack.
- Ignored events:
  - beg_op outside IDLE (including in the same cycle as ack in DONE); no queuing, the requester must re-issue.
  - core_done outside RUN.
  - ack outside DONE.
- Zero sign rule: (+0)×x = ±0 per the XOR of signs. Inf×0 is not handled here; it is flagged elsewhere.
- Back-to-back throughput: minimum 4 cycles per zero-bypass operation (IDLE, LOAD, CHECK, DONE).

Decomposition:
- Shared package:
  - state encoding constants (IDLE, LOAD, CHECK, RUN, DONE; 3-bit);
  - width constants for single (32) and double (64) precision.
- One natural sub-module: timeout_counter, a CW-bit counter with clear, enable, async reset and terminal-count output compared against TMO-1.
- The FSM and the output registers stay in the top module.

Test Plan:
- Zero bypass: sign_a=1, sign_b=0, zero_m_flag=1 in CHECK.
  - Expect ready on cycle 3 after beg_op, result=32'h8000_0000, zero_bypass=1, core_start never asserted.
- Normal path: zero_m_flag=0, core_done 5 cycles after core_start with core_result=32'h4040_0000.
  - Expect result=32'h4040_0000, ready=1, zero_bypass=0, timeout_err=0.
- Timeout, TMO=64: core_done never arrives.
  - Expect core_abort pulse exactly 64 cycles after entering RUN, then timeout_err=1, result=0, ready=1.
- Race at expiry: core_done asserted in the expiry cycle with core_result=32'h3F80_0000.
  - Expect no core_abort, result=32'h3F80_0000, timeout_err=0.
- Handshake: hold ack=0 for 10 cycles in DONE; ready and result stay stable. Pulse beg_op in RUN and DONE: it is ignored.
  - ack=1 → ready=0 next cycle; a new beg_op is then accepted.
- Async reset asserted in RUN (W=64):
  - All outputs 0 immediately, no core_abort pulse, state IDLE.
  - A subsequent zero op with sign_a=sign_b=1 gives result=64'h0.
